sound_mailbox: RTL and testbench
================================

# sound_mailbox

Main-CPU-side mailbox and control block for the I/O and sound 6502. It is the 68010 end of the `WR68k_b`/`RD68k_b` interface. It latches 68k sound commands and raises `SNDNMI_b` to the 6502. It latches 6502 responses and raises a 68k interrupt. It also generates the timed `SNDRST_b` pulse. It sits between the main CPU bus decode and the sound board's 6502 data buses (`SDout` in, `SDin` out).

## Interface
- `NMI_CYCLES`, default 4: width of the `SNDNMI_b` low pulse in `clk` cycles (at least 1).
- `RST_CYCLES`, default 16: width of the `SNDRST_b` low pulse in `clk` cycles (at least 1).

Ports:
- `clk` in 1: single clock. All strobes are sampled on its rising edge.
- `reset` in 1: **asynchronous, active-high** reset.
- `m_din` in 8: 68k write data.
- `m_cmd_wr_b` in 1: 68k command-latch write strobe, active low.
- `m_resp_rd_b` in 1: 68k response-latch read strobe, active low.
- `m_stat_rd_b` in 1: 68k status read strobe, active low.
- `m_sndrst_wr_b` in 1: 68k sound-reset request strobe, active low.
- `m_dout` out 8: registered 68k read data.
- `m_irq_b` out 1: 68k interrupt, active low. Equals `~resp_full`.
- `SDout` in 8: 6502 write data.
- `WR68k_b` in 1: 6502 response-latch write strobe, active low.
- `RD68k_b` in 1: 6502 command-latch read strobe, active low.
- `SDin_o` out 8: command latch value toward the 6502 bus.
- `SDin_en` out 1: high while `RD68k_b` is low and the block is not in sound reset. The top level tristates `SDin` with this.
- `SNDNMI_b` out 1: 6502 NMI, active low.
- `SNDRST_b` out 1: 6502 and sound-board reset, active low.
- `cmd_full` out 1: command latch holds an unread command.

## Operation
- **Strobe detection.** Each strobe is registered once. An *event* is the first rising edge at which the strobe samples 0 after having sampled 1. A strobe held low produces exactly one event.
- **Command write** (`m_cmd_wr_b` event):
  - `cmd_lat <= m_din` and `cmd_full <= 1`.
  - If `cmd_full` was already 1, sticky `overrun <= 1`. The new data overwrites the latch.
  - NMI counter loads `NMI_CYCLES`.
- **NMI.** `SNDNMI_b = 0` while the NMI counter is nonzero; the counter decrements each cycle. A new command write during a pulse reloads the counter.
- **Command read** (`RD68k_b` event): `cmd_full <= 0`. `SDin_o = cmd_lat` at all times.
- **Response write** (`WR68k_b` event): `resp_lat <= SDout` and `resp_full <= 1`.
- **Response read** (`m_resp_rd_b` event): `resp_full <= 0`.
- **Status read** (`m_stat_rd_b` event): clears `overrun` after the status value has been captured.
- **68k read data.** `m_dout` is updated every cycle:
  - `resp_lat` while `m_resp_rd_b` is low.
  - Otherwise `{5'b0, overrun, cmd_full, resp_full}` while `m_stat_rd_b` is low.
  - Otherwise `8'h00`.
  - If both read strobes are low, the response read has priority.
- **Sound reset** (`m_sndrst_wr_b` event):
  - Reset counter loads `RST_CYCLES`; `SNDRST_b = 0` while the counter is nonzero.
  - The event clears `cmd_full`, `resp_full`, `overrun` and the NMI counter.
  - While in reset, `WR68k_b`/`RD68k_b` events are ignored, `SDin_en = 0`, `SNDNMI_b = 1`, and NMI loads are suppressed.
  - 68k command writes still latch data and set `cmd_full`.
  - An event during an active pulse reloads the counter.
- **Simultaneous events in one cycle:**
  - Command write and command read: `cmd_full` ends 1 and `SDin_o` shows the old value that cycle.
  - Response write and response read: `resp_full` ends 1 and `m_dout` shows the old `resp_lat`.

## Timing
- **`reset` assertion**, asynchronous:
  - `cmd_lat = resp_lat = 0`, and all flags are 0.
  - `m_dout = 8'h00`, `m_irq_b = 1`, `SNDNMI_b = 1`, `SDin_en = 0`.
  - `SNDRST_b = 0`, reset counter = `RST_CYCLES`.
  - The strobe history registers are set to 1, so a strobe low at release produces an event.
- **After release**, `SNDRST_b` stays low for `RST_CYCLES` rising edges, then goes high. This is the power-on reset of the sound CPU.
- **Event latency.** An event is detected at edge N. Latches and flags update at edge N. `m_irq_b`, `cmd_full` and the status bits reflect the change from edge N.
- **NMI.** `SNDNMI_b` goes low at edge N, after a command write event, and goes high at edge N+`NMI_CYCLES`.
- **`m_dout`** is valid one edge after the read strobe is sampled low.
- **Counters** are sized to `$clog2(max+1)` bits and saturate at 0 (no wrap).
- **`reset` mid-pulse** aborts both pulses. The power-on `SNDRST_b` sequence restarts.

## Test plan
- **Power-on.** Release `reset` → `SNDRST_b` low exactly 16 cycles, then high; all other outputs at their reset values.
- **Command path.**
  - Stimulus: 68k writes `8'hA5`.
  - Required: `cmd_full = 1`; `SNDNMI_b` low exactly 4 cycles; 6502 `RD68k_b` low 3 cycles gives `SDin_en = 1` and `SDin_o = 8'hA5`.
  - Then: `cmd_full` clears on the first low cycle only.
- **Response path.** 6502 writes `8'h3C` → `m_irq_b = 0`. 68k response read gives `m_dout = 8'h3C` and `m_irq_b = 1`.
- **Overrun.** Write `8'h11` then `8'h22` with no read → status read returns `8'h06`. A following status read returns `8'h02`; the latch holds `8'h22`.
- **Simultaneous.** 68k command write `8'h55` in the same cycle as a 6502 command read of `8'hA5` → `SDin_o = 8'hA5` that cycle, `cmd_full = 1` afterwards, and a new NMI pulse.
- **Sound reset mid-traffic.** With `cmd_full = resp_full = 1` and an NMI pulse active, issue a sound-reset event:
  - Flags clear, `SNDNMI_b = 1`, `SNDRST_b` low 16 cycles.
  - A `WR68k_b` pulse during reset leaves `resp_full = 0`.

Source files
------------

// File: rtl/sound_mailbox.sv
// -----------------------------------------------------------------------------
// sound_mailbox
//
// Main-CPU (68010) side of the mailbox between the 68k and the I/O / sound
// 6502. It holds one command byte going to the 6502 and one response byte
// coming back. A new command pulses SNDNMI_b to wake the 6502. A new response
// raises the 68k interrupt. The block also produces the timed SNDRST_b pulse,
// both at power-on and on request from the 68k.
//
// Parameters
//   NMI_CYCLES    width of the SNDNMI_b low pulse, in clk cycles (>= 1)
//   RST_CYCLES    width of the SNDRST_b low pulse, in clk cycles (>= 1)
//
// Ports
//   clk            single clock; every strobe is sampled on its rising edge
//   reset          asynchronous, active-high reset
//   m_din          68k write data (command byte)
//   m_cmd_wr_b     68k command-latch write strobe, active low
//   m_resp_rd_b    68k response-latch read strobe, active low
//   m_stat_rd_b    68k status read strobe, active low
//   m_sndrst_wr_b  68k sound-reset request strobe, active low
//   m_dout         registered 68k read data
//   m_irq_b        68k interrupt, active low; low while a response is pending
//   SDout          6502 write data (response byte)
//   WR68k_b        6502 response-latch write strobe, active low
//   RD68k_b        6502 command-latch read strobe, active low
//   SDin_o         command latch value driven toward the 6502 bus
//   SDin_en        tristate enable for SDin; high while RD68k_b is low and the
//                  sound board is out of reset
//   SNDNMI_b       6502 NMI, active low
//   SNDRST_b       6502 / sound-board reset, active low
//   cmd_full       command latch holds a command the 6502 has not yet read
// -----------------------------------------------------------------------------
module sound_mailbox #(
    parameter int NMI_CYCLES = 4,
    parameter int RST_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] m_din,
    input  logic       m_cmd_wr_b,
    input  logic       m_resp_rd_b,
    input  logic       m_stat_rd_b,
    input  logic       m_sndrst_wr_b,
    output logic [7:0] m_dout,
    output logic       m_irq_b,
    input  logic [7:0] SDout,
    input  logic       WR68k_b,
    input  logic       RD68k_b,
    output logic [7:0] SDin_o,
    output logic       SDin_en,
    output logic       SNDNMI_b,
    output logic       SNDRST_b,
    output logic       cmd_full
);

    localparam int NMI_W = $clog2(NMI_CYCLES + 1);
    localparam int RST_W = $clog2(RST_CYCLES + 1);

    localparam logic [NMI_W-1:0] NMI_LOAD = NMI_W'(NMI_CYCLES);
    localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES);
    localparam logic [NMI_W-1:0] NMI_ONE  = NMI_W'(1);
    localparam logic [RST_W-1:0] RST_ONE  = RST_W'(1);

    // Strobe bundle, one bit per active-low strobe.
    localparam int N_STB    = 6;
    localparam int S_CMD_WR = 0;
    localparam int S_RESP_RD = 1;
    localparam int S_STAT_RD = 2;
    localparam int S_SNDRST = 3;
    localparam int S_WR68K  = 4;
    localparam int S_RD68K  = 5;

    logic [N_STB-1:0] stb_b;
    logic [N_STB-1:0] stb_hist_reg;
    logic [N_STB-1:0] stb_evt;

    assign stb_b = {RD68k_b, WR68k_b, m_sndrst_wr_b, m_stat_rd_b, m_resp_rd_b, m_cmd_wr_b};

    // History of each strobe as sampled at the previous edge. It resets to 1
    // so that a strobe already low when reset is released still gives an event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stb_hist_reg <= '1;
        end else begin
            stb_hist_reg <= stb_b;
        end
    end

    // An event is the first edge at which a strobe samples low after it sampled
    // high, so a strobe held low produces exactly one event.
    genvar gi;
    generate
        for (gi = 0; gi < N_STB; gi++) begin : g_evt
            assign stb_evt[gi] = stb_hist_reg[gi] & ~stb_b[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]       cmd_lat_reg,   cmd_lat_next;
    logic [7:0]       resp_lat_reg,  resp_lat_next;
    logic             cmd_full_reg,  cmd_full_next;
    logic             resp_full_reg, resp_full_next;
    logic             overrun_reg,   overrun_next;
    logic [NMI_W-1:0] nmi_cnt_reg,   nmi_cnt_next;
    logic [RST_W-1:0] rst_cnt_reg,   rst_cnt_next;
    logic [7:0]       m_dout_reg,    m_dout_next;

    logic in_snd_rst;
    logic cmd_rd_ok;
    logic resp_wr_ok;

    // The sound board is held in reset for as long as the reset counter runs.
    assign in_snd_rst = (rst_cnt_reg != '0);

    // 6502-side events are meaningless while the 6502 is held in reset.
    assign cmd_rd_ok  = stb_evt[S_RD68K] & ~in_snd_rst;
    assign resp_wr_ok = stb_evt[S_WR68K] & ~in_snd_rst;

    always_comb begin
        cmd_lat_next   = cmd_lat_reg;
        resp_lat_next  = resp_lat_reg;
        cmd_full_next  = cmd_full_reg;
        resp_full_next = resp_full_reg;
        overrun_next   = overrun_reg;
        m_dout_next    = 8'h00;

        // Both pulse counters count down to zero and stop there.
        nmi_cnt_next = (nmi_cnt_reg != '0) ? (nmi_cnt_reg - NMI_ONE) : '0;
        rst_cnt_next = (rst_cnt_reg != '0) ? (rst_cnt_reg - RST_ONE) : '0;

        // Read data is captured from the pre-edge state, so a status read sees
        // overrun before the same event clears it, and a response read sees the
        // old response byte even if the 6502 overwrites it on this edge.
        if (!m_resp_rd_b) begin
            m_dout_next = resp_lat_reg;
        end else if (!m_stat_rd_b) begin
            m_dout_next = {5'b0, overrun_reg, cmd_full_reg, resp_full_reg};
        end

        // Clears are applied first so that a coincident write wins.
        if (cmd_rd_ok) begin
            cmd_full_next = 1'b0;
        end
        if (stb_evt[S_STAT_RD]) begin
            overrun_next = 1'b0;
        end
        if (stb_evt[S_RESP_RD]) begin
            resp_full_next = 1'b0;
        end

        // The 68k can still queue a command while the sound board is in reset;
        // it just does not get an NMI for it.
        if (stb_evt[S_CMD_WR]) begin
            cmd_lat_next  = m_din;
            cmd_full_next = 1'b1;
            if (cmd_full_reg) begin
                overrun_next = 1'b1;
            end
            if (!in_snd_rst) begin
                nmi_cnt_next = NMI_LOAD;
            end
        end

        if (resp_wr_ok) begin
            resp_lat_next  = SDout;
            resp_full_next = 1'b1;
        end

        // A sound-reset request restarts the reset pulse and discards any
        // handshake state so both sides start from an empty mailbox.
        if (stb_evt[S_SNDRST]) begin
            rst_cnt_next   = RST_LOAD;
            cmd_full_next  = 1'b0;
            resp_full_next = 1'b0;
            overrun_next   = 1'b0;
            nmi_cnt_next   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_lat_reg   <= 8'h00;
            resp_lat_reg  <= 8'h00;
            cmd_full_reg  <= 1'b0;
            resp_full_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            nmi_cnt_reg   <= '0;
            // Power-on: the sound CPU is held in reset for RST_CYCLES edges
            // after release.
            rst_cnt_reg   <= RST_LOAD;
            m_dout_reg    <= 8'h00;
        end else begin
            cmd_lat_reg   <= cmd_lat_next;
            resp_lat_reg  <= resp_lat_next;
            cmd_full_reg  <= cmd_full_next;
            resp_full_reg <= resp_full_next;
            overrun_reg   <= overrun_next;
            nmi_cnt_reg   <= nmi_cnt_next;
            rst_cnt_reg   <= rst_cnt_next;
            m_dout_reg    <= m_dout_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign m_dout   = m_dout_reg;
    assign m_irq_b  = ~resp_full_reg;
    assign cmd_full = cmd_full_reg;
    assign SDin_o   = cmd_lat_reg;
    assign SDin_en  = ~RD68k_b & ~in_snd_rst;
    // The NMI counter is already zero during reset; the gate keeps the NMI
    // line quiet regardless.
    assign SNDNMI_b = (nmi_cnt_reg == '0) | in_snd_rst;
    assign SNDRST_b = ~in_snd_rst;

endmodule

// File: tb/tb_sound_mailbox.sv
// -----------------------------------------------------------------------------
// tb_sound_mailbox
//
// Self-checking bench for sound_mailbox. A behavioural model of the mailbox
// (plain integers for latches, flags and remaining pulse lengths) is stepped
// on every clock edge and all DUT outputs are compared against it after each
// edge. Directed sequences follow the test plan with spec-derived constants,
// then a randomized phase exercises arbitrary strobe traffic including an
// asynchronous reset mid-run.
// -----------------------------------------------------------------------------
module tb_sound_mailbox;

    localparam int NMI_N = 4;
    localparam int RST_N = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] m_din;
    logic       m_cmd_wr_b;
    logic       m_resp_rd_b;
    logic       m_stat_rd_b;
    logic       m_sndrst_wr_b;
    logic [7:0] m_dout;
    logic       m_irq_b;
    logic [7:0] SDout;
    logic       WR68k_b;
    logic       RD68k_b;
    logic [7:0] SDin_o;
    logic       SDin_en;
    logic       SNDNMI_b;
    logic       SNDRST_b;
    logic       cmd_full;

    sound_mailbox #(.NMI_CYCLES(NMI_N), .RST_CYCLES(RST_N)) dut (
        .clk           (clk),
        .reset         (reset),
        .m_din         (m_din),
        .m_cmd_wr_b    (m_cmd_wr_b),
        .m_resp_rd_b   (m_resp_rd_b),
        .m_stat_rd_b   (m_stat_rd_b),
        .m_sndrst_wr_b (m_sndrst_wr_b),
        .m_dout        (m_dout),
        .m_irq_b       (m_irq_b),
        .SDout         (SDout),
        .WR68k_b       (WR68k_b),
        .RD68k_b       (RD68k_b),
        .SDin_o        (SDin_o),
        .SDin_en       (SDin_en),
        .SNDNMI_b      (SNDNMI_b),
        .SNDRST_b      (SNDRST_b),
        .cmd_full      (cmd_full)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int md_cmd_lat, md_resp_lat, md_dout;
    int md_cfull, md_rfull, md_ovr;
    int md_nmi_left, md_rst_left;
    bit p_cw, p_rr, p_sr, p_rst, p_wr, p_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        md_cmd_lat  = 0;
        md_resp_lat = 0;
        md_dout     = 0;
        md_cfull    = 0;
        md_rfull    = 0;
        md_ovr      = 0;
        md_nmi_left = 0;
        md_rst_left = RST_N;
        p_cw = 1; p_rr = 1; p_sr = 1; p_rst = 1; p_wr = 1; p_rd = 1;
    endtask

    // One rising edge of the mailbox, from the inputs present at that edge.
    task automatic model_step();
        bit e_cw, e_rr, e_sr, e_rst, e_wr, e_rd, busy;
        int old_cfull;
        e_cw  = !m_cmd_wr_b    && p_cw;
        e_rr  = !m_resp_rd_b   && p_rr;
        e_sr  = !m_stat_rd_b   && p_sr;
        e_rst = !m_sndrst_wr_b && p_rst;
        e_wr  = !WR68k_b       && p_wr;
        e_rd  = !RD68k_b       && p_rd;
        busy  = (md_rst_left > 0);
        old_cfull = md_cfull;

        if (!m_resp_rd_b)      md_dout = md_resp_lat;
        else if (!m_stat_rd_b) md_dout = md_ovr * 4 + md_cfull * 2 + md_rfull;
        else                   md_dout = 0;

        if (md_nmi_left > 0) md_nmi_left--;
        if (md_rst_left > 0) md_rst_left--;

        if (e_rd && !busy) md_cfull = 0;
        if (e_sr) md_ovr = 0;
        if (e_rr) md_rfull = 0;
        if (e_cw) begin
            md_cmd_lat = m_din;
            md_cfull   = 1;
            if (old_cfull == 1) md_ovr = 1;
            if (!busy) md_nmi_left = NMI_N;
        end
        if (e_wr && !busy) begin
            md_resp_lat = SDout;
            md_rfull    = 1;
        end
        if (e_rst) begin
            md_rst_left = RST_N;
            md_cfull    = 0;
            md_rfull    = 0;
            md_ovr      = 0;
            md_nmi_left = 0;
        end

        p_cw = m_cmd_wr_b; p_rr = m_resp_rd_b; p_sr = m_stat_rd_b;
        p_rst = m_sndrst_wr_b; p_wr = WR68k_b; p_rd = RD68k_b;
    endtask

    task automatic compare_all();
        chk("m_dout",   m_dout,   md_dout[7:0]);
        chk("m_irq_b",  m_irq_b,  (md_rfull == 0));
        chk("cmd_full", cmd_full, (md_cfull == 1));
        chk("SDin_o",   SDin_o,   md_cmd_lat[7:0]);
        chk("SDin_en",  SDin_en,  (!RD68k_b && md_rst_left == 0));
        chk("SNDNMI_b", SNDNMI_b, (md_nmi_left == 0 || md_rst_left > 0));
        chk("SNDRST_b", SNDRST_b, (md_rst_left == 0));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_strobes();
        m_cmd_wr_b = 1; m_resp_rd_b = 1; m_stat_rd_b = 1; m_sndrst_wr_b = 1;
        WR68k_b = 1; RD68k_b = 1;
    endtask

    task automatic cmd_write(input logic [7:0] d);
        m_din = d; m_cmd_wr_b = 0;
        tick();
        m_cmd_wr_b = 1;
    endtask

    initial begin
        int edges;
        reset = 1'b1;
        m_din = 8'h00;
        SDout = 8'h00;
        idle_strobes();
        model_reset();

        // Reset values.
        #2;
        chk("rst_m_dout",   m_dout,   8'h00);
        chk("rst_m_irq_b",  m_irq_b,  1'b1);
        chk("rst_SNDNMI_b", SNDNMI_b, 1'b1);
        chk("rst_SDin_en",  SDin_en,  1'b0);
        chk("rst_SNDRST_b", SNDRST_b, 1'b0);
        chk("rst_cmd_full", cmd_full, 1'b0);
        chk("rst_SDin_o",   SDin_o,   8'h00);
        @(negedge clk);
        reset = 1'b0;

        // Power-on sound reset.
        edges = 0;
        while (SNDRST_b == 1'b0 && edges < 100) begin
            tick();
            edges++;
        end
        chk("porst_edges", edges, RST_N);
        tick();

        // Command path.
        cmd_write(8'hA5);
        chk("cmd_full_set", cmd_full, 1'b1);
        chk("nmi_low_now", SNDNMI_b, 1'b0);
        edges = 0;
        while (SNDNMI_b == 1'b0 && edges < 100) begin
            tick();
            edges++;
        end
        chk("nmi_edges", edges, NMI_N);
        RD68k_b = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rd_SDin_en", SDin_en, 1'b1);
            chk("rd_SDin_o",  SDin_o,  8'hA5);
            chk("rd_cmd_full", cmd_full, 1'b0);
        end
        RD68k_b = 1;
        tick();
        chk("rd_SDin_en_off", SDin_en, 1'b0);

        // Response path.
        SDout = 8'h3C; WR68k_b = 0;
        tick();
        WR68k_b = 1;
        chk("resp_irq_low", m_irq_b, 1'b0);
        m_resp_rd_b = 0;
        tick();
        m_resp_rd_b = 1;
        chk("resp_dout", m_dout, 8'h3C);
        chk("resp_irq_high", m_irq_b, 1'b1);
        tick();
        chk("resp_dout_idle", m_dout, 8'h00);

        // Overrun.
        cmd_write(8'h11);
        tick();
        cmd_write(8'h22);
        tick();
        m_stat_rd_b = 0;
        tick();
        m_stat_rd_b = 1;
        chk("ovr_status1", m_dout, 8'h06);
        tick();
        m_stat_rd_b = 0;
        tick();
        m_stat_rd_b = 1;
        chk("ovr_status2", m_dout, 8'h02);
        chk("ovr_latch", SDin_o, 8'h22);
        tick();

        // Simultaneous command write and command read.
        RD68k_b = 0;
        tick();
        RD68k_b = 1;
        tick();
        cmd_write(8'hA5);
        for (int i = 0; i < NMI_N + 1; i++) tick();
        m_din = 8'h55; m_cmd_wr_b = 0; RD68k_b = 0;
        #1;
        chk("sim_SDin_o_pre", SDin_o, 8'hA5);
        chk("sim_SDin_en_pre", SDin_en, 1'b1);
        tick();
        m_cmd_wr_b = 1; RD68k_b = 1;
        chk("sim_cmd_full", cmd_full, 1'b1);
        chk("sim_nmi", SNDNMI_b, 1'b0);
        chk("sim_SDin_o_post", SDin_o, 8'h55);
        for (int i = 0; i < NMI_N + 1; i++) tick();

        // Sound reset mid-traffic.
        SDout = 8'h77; WR68k_b = 0;
        tick();
        WR68k_b = 1;
        cmd_write(8'h99);
        chk("sr_pre_irq", m_irq_b, 1'b0);
        chk("sr_pre_cfull", cmd_full, 1'b1);
        chk("sr_pre_nmi", SNDNMI_b, 1'b0);
        m_sndrst_wr_b = 0;
        tick();
        m_sndrst_wr_b = 1;
        chk("sr_cfull", cmd_full, 1'b0);
        chk("sr_irq", m_irq_b, 1'b1);
        chk("sr_nmi", SNDNMI_b, 1'b1);
        chk("sr_rst_low", SNDRST_b, 1'b0);
        edges = 0;
        while (SNDRST_b == 1'b0 && edges < 100) begin
            WR68k_b = (edges == 2) ? 1'b0 : 1'b1;
            tick();
            edges++;
        end
        WR68k_b = 1;
        chk("sr_edges", edges, RST_N);
        chk("sr_wr_ignored", m_irq_b, 1'b1);
        m_stat_rd_b = 0;
        tick();
        m_stat_rd_b = 1;
        chk("sr_status", m_dout, 8'h00);
        tick();

        // Randomized traffic against the model, with one async reset.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) begin
                reset = 1'b1;
                #1;
                model_reset();
                compare_all();
                tick();
                reset = 1'b0;
            end
            m_din         = 8'($urandom);
            SDout         = 8'($urandom);
            m_cmd_wr_b    = ($urandom_range(0, 3) != 0);
            m_resp_rd_b   = ($urandom_range(0, 3) != 0);
            m_stat_rd_b   = ($urandom_range(0, 3) != 0);
            WR68k_b       = ($urandom_range(0, 2) != 0);
            RD68k_b       = ($urandom_range(0, 2) != 0);
            m_sndrst_wr_b = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
